// File: rtl/rect_pkg.sv
// rtl/rect_pkg.sv - shared state encoding and width defaults for the rectangle render path
// Contents: state_t (draw engine states), DEF_X_W / DEF_Y_W / DEF_COLOR_W
// (coordinate and colour widths shared with the controller and VGA adapter),
// cnt_w() (counter width for a square side, never below 1 bit).
package rect_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_COLOR_W = 3;

  function automatic int cnt_w(input int box);
    return (box > 1) ? $clog2(box) : 1;
  endfunction

endpackage

// File: rtl/box_counter.sv
// rtl/box_counter.sv - row-major 2-D column/row counter for a BOX x BOX scan
// Ports: clk, resetn (async active-low), clr (zero both counters),
// adv (step one pixel), cx/cy (column/row), last (cx = cy = BOX-1).
module box_counter
  import rect_pkg::*;
#(
  parameter int BOX = 4,
  parameter int CW  = cnt_w(BOX)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] cx,
  output logic [CW-1:0] cy,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(BOX - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clr) begin
      cx <= '0;
      cy <= '0;
    end else if (adv) begin
      if (cx == MAX) begin
        cx <= '0;
        cy <= (cy == MAX) ? '0 : cy + CW'(1);
      end else begin
        cx <= cx + CW'(1);
      end
    end
  end

  assign last = (cx == MAX) && (cy == MAX);

endmodule

// File: rtl/rect_draw_engine.sv
// rtl/rect_draw_engine.sv - origin registers plus BOX x BOX pixel scan toward the VGA adapter
// Ports: clk, resetn (async active-low); ld_x/ld_y/data_in load the origin in
// idle; start_count starts a draw, latching color_in; wr_ready accepts the
// current plot write; x_out/y_out/color_out/plot form the write; busy covers
// draw and completion; done pulses for one cycle at the end.
// Option macro RECT_DRAW_CLIP_EN: pixels whose coordinate addition carries out
// are skipped (plot low, no wait for wr_ready) instead of wrapping.
module rect_draw_engine
  import rect_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int BOX     = 4,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld_x,
  input  logic               ld_y,
  input  logic               start_count,
  input  logic [X_W-1:0]     data_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               wr_ready,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_w(BOX);

  state_t             state, state_nx;
  logic [X_W-1:0]     x_reg, x_org;
  logic [Y_W-1:0]     y_reg, y_org;
  logic [COLOR_W-1:0] col_reg;
  logic [CW-1:0]      cx, cy;
  logic               last, accept, adv, off;

  assign accept = (state == S_IDLE) && start_count;

  // The draw runs from a snapshot of the origin taken at start, so a load
  // arriving together with start_count updates x_reg/y_reg for the next draw
  // without disturbing the one being started.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      x_reg   <= '0;
      y_reg   <= '0;
      x_org   <= '0;
      y_org   <= '0;
      col_reg <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && ld_x) x_reg <= data_in;
      if ((state == S_IDLE) && ld_y) y_reg <= data_in[Y_W-1:0];
      if (accept) begin
        x_org   <= x_reg;
        y_org   <= y_reg;
        col_reg <= color_in;
      end
    end
  end

  box_counter #(.BOX(BOX), .CW(CW)) u_box_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept),
    .adv    (adv),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

`ifdef RECT_DRAW_CLIP_EN
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  assign x_sum = {1'b0, x_org} + (X_W + 1)'(cx);
  assign y_sum = {1'b0, y_org} + (Y_W + 1)'(cy);
  assign off   = x_sum[X_W] | y_sum[Y_W];
  assign x_out = x_sum[X_W-1:0];
  assign y_out = y_sum[Y_W-1:0];
`else
  assign off   = 1'b0;
  assign x_out = x_org + X_W'(cx);
  assign y_out = y_org + Y_W'(cy);
`endif

  assign color_out = col_reg;

  // Outputs decode only registered state; wr_ready steers adv alone.
  always_comb begin
    state_nx = state;
    plot     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    adv      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_count) state_nx = S_DRAW;
      end
      S_DRAW: begin
        busy = 1'b1;
        plot = !off;
        adv  = wr_ready | off;
        if (adv && last) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
